// File: rtl/smoother_output_writer.sv
// Output stage of the image smoother: writes accepted rows to consecutive output-RAM addresses.
// Optional ping-pong bank bit on the address MSB when OUTCTL_BANK_EN is defined.
module smoother_output_writer #(
    parameter int DATA_W   = 1024,
    parameter int DEPTH    = 128,
    parameter int ADDR_W   = 7,
    parameter int INTERVAL = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              ram_we,
`ifdef OUTCTL_BANK_EN
    output logic [ADDR_W:0]   ram_address,
`else
    output logic [ADDR_W-1:0] ram_address,
`endif
    output logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              conv_done
);

    localparam int CNT_W = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  GAP_LOAD = CNT_W'(INTERVAL - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] idx, idx_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic              we_nx;
    logic              accept;
`ifdef OUTCTL_BANK_EN
    logic              bank, bank_nx;
`endif

    assign busy      = (state == S_RUN);
    assign conv_done = (state == S_DONE);

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        cnt_nx   = cnt;
        we_nx    = 1'b0;
`ifdef OUTCTL_BANK_EN
        bank_nx  = bank;
`endif
        in_ready = (state == S_RUN) && (cnt == '0);
        accept   = in_valid && in_ready;

        if (cnt != '0) begin
            cnt_nx = cnt - CNT_W'(1);
        end

        // abort wins over start and over a same-cycle accept, so no write is issued
        if (abort) begin
            state_nx = S_IDLE;
            idx_nx   = '0;
            cnt_nx   = '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_nx = S_RUN;
                        idx_nx   = '0;
                        cnt_nx   = '0;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        we_nx  = 1'b1;
                        cnt_nx = GAP_LOAD;
                        if (idx == LAST_IDX) begin
                            state_nx = S_DONE;
                            idx_nx   = '0;
`ifdef OUTCTL_BANK_EN
                            bank_nx  = ~bank;
`endif
                        end else begin
                            idx_nx = idx + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                    state_nx = S_IDLE;
                    idx_nx   = '0;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            idx         <= '0;
            cnt         <= '0;
            ram_we      <= 1'b0;
            ram_address <= '0;
            data_out    <= '0;
`ifdef OUTCTL_BANK_EN
            bank        <= 1'b0;
`endif
        end else begin
            state  <= state_nx;
            idx    <= idx_nx;
            cnt    <= cnt_nx;
            ram_we <= we_nx;
`ifdef OUTCTL_BANK_EN
            bank   <= bank_nx;
`endif
            // address/data are only loaded on a write and hold otherwise
            if (we_nx) begin
`ifdef OUTCTL_BANK_EN
                ram_address <= {bank, idx};
`else
                ram_address <= idx;
`endif
                data_out    <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_smoother_output_writer.sv
// Bench for smoother_output_writer: three instances (INTERVAL 4, 1, 2) on shared stimulus,
// a directed vector table, hand sequences and random traffic against a frame-level model.
module tb_smoother_output_writer;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
`ifdef OUTCTL_BANK_EN
    localparam int AOW   = AW + 1;
    localparam int B1    = 1 << AW;
`else
    localparam int AOW   = AW;
    localparam int B1    = 0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;

    logic           rdy[3];
    logic           we[3];
    logic           busy[3];
    logic           done[3];
    logic [AOW-1:0] addr[3];
    logic [DW-1:0]  dout[3];

    always #5 clk = ~clk;

    smoother_output_writer #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .INTERVAL(4)) u4 (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(rdy[0]), .ram_we(we[0]),
        .ram_address(addr[0]), .data_out(dout[0]), .busy(busy[0]), .conv_done(done[0]));

    smoother_output_writer #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .INTERVAL(1)) u1 (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(rdy[1]), .ram_we(we[1]),
        .ram_address(addr[1]), .data_out(dout[1]), .busy(busy[1]), .conv_done(done[1]));

    smoother_output_writer #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .INTERVAL(2)) u2 (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(rdy[2]), .ram_we(we[2]),
        .ram_address(addr[2]), .data_out(dout[2]), .busy(busy[2]), .conv_done(done[2]));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Frame-level model: rows written so far, cycles since last accept, bank parity
    int ivs[3] = '{4, 1, 2};
    bit m_run[3];
    bit m_done[3];
    bit m_we[3];
    int m_rows[3];
    int m_since[3];
    int m_bank[3];
    int m_addr[3];
    int m_data[3];

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            m_run[i] = 0; m_done[i] = 0; m_we[i] = 0; m_rows[i] = 0;
            m_since[i] = 0; m_bank[i] = 0; m_addr[i] = 0; m_data[i] = 0;
        end
    endtask

    always @(negedge reset_n) model_clear();

    always @(posedge clk) begin
        bit acc;
        if (!reset_n) begin
            model_clear();
        end else begin
            for (int i = 0; i < 3; i++) begin
                acc = m_run[i] && in_valid && (m_since[i] >= ivs[i]);
                m_we[i] = 0;
                if (abort) begin
                    m_run[i] = 0; m_done[i] = 0; m_rows[i] = 0;
                end else if (!m_run[i] && start) begin
                    m_run[i] = 1; m_done[i] = 0; m_rows[i] = 0; m_since[i] = ivs[i];
                end else if (acc) begin
                    m_we[i]   = 1;
                    m_addr[i] = m_bank[i] * B1 + m_rows[i];
                    m_data[i] = int'(in_data);
                    m_rows[i]++;
                    m_since[i] = 1;
                    if (m_rows[i] == DEPTH) begin
                        m_run[i] = 0; m_done[i] = 1; m_rows[i] = 0;
                        m_bank[i] = 1 - m_bank[i];
                    end
                end else if (m_run[i] && m_since[i] < ivs[i]) begin
                    m_since[i]++;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("m%0d_ready", i), 32'(rdy[i]),  32'(m_run[i] && m_since[i] >= ivs[i]));
            chk($sformatf("m%0d_busy", i),  32'(busy[i]), 32'(m_run[i]));
            chk($sformatf("m%0d_done", i),  32'(done[i]), 32'(m_done[i]));
            chk($sformatf("m%0d_we", i),    32'(we[i]),   32'(m_we[i]));
            chk($sformatf("m%0d_addr", i),  32'(addr[i]), 32'(m_addr[i]));
            chk($sformatf("m%0d_data", i),  32'(dout[i]), 32'(m_data[i]));
        end
    end

    typedef struct {
        bit            st;
        bit            ab;
        bit            v;
        logic [DW-1:0] d;
        bit            e_we;
        int            e_addr;
        int            e_data;
        bit            e_rdy;
        bit            e_busy;
        bit            e_done;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit st, bit ab, bit v, int d, bit e_we, int e_addr, int e_data,
                                bit e_rdy, bit e_busy, bit e_done);
        vec_t r;
        r.st = st; r.ab = ab; r.v = v; r.d = DW'(d);
        r.e_we = e_we; r.e_addr = e_addr; r.e_data = e_data;
        r.e_rdy = e_rdy; r.e_busy = e_busy; r.e_done = e_done;
        return r;
    endfunction

    task automatic run_frame(input int f);
        int n;
        n = 0;
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1;
        for (int c = 0; c < 60 && n < DEPTH; c++) begin
            in_data = DW'($urandom);
            @(negedge clk);
            if (we[0]) begin
                chk($sformatf("frame%0d_addr%0d", f, n), 32'(addr[0]), 32'(((f % 2) * B1) + n));
                chk($sformatf("frame%0d_data%0d", f, n), 32'(dout[0]), 32'(in_data));
                n++;
            end
            #1;
        end
        chk($sformatf("frame%0d_rows", f), 32'(n), 32'(DEPTH));
        chk($sformatf("frame%0d_done", f), 32'(done[0]), 32'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int found;
        int dval;

        // INTERVAL=4 frame with valid held: accepts every 4th edge, then DONE
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        for (int r = 0; r < DEPTH; r++) begin
            dval = (r + 1) * 8'h11;
            tbl.push_back(mk(0, 0, 1, dval, 1, r, dval, 0, r < DEPTH - 1, r == DEPTH - 1));
            if (r < DEPTH - 1)
                for (int w = 0; w < 3; w++)
                    tbl.push_back(mk(0, 0, 1, dval + 8'h11, 0, r, dval, w == 2, 1, 0));
        end
        tbl.push_back(mk(0, 0, 1, 8'h55, 0, 3, 8'h44, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 8'h55, 0, 3, 8'h44, 1, 1, 0));
        tbl.push_back(mk(0, 0, 1, 8'h66, 1, B1, 8'h66, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 8'h77, 0, B1, 8'h66, 0, 0, 0));

        repeat (3) @(negedge clk);
        chk("reset_we",    32'(we[0]),   32'd0);
        chk("reset_addr",  32'(addr[0]), 32'd0);
        chk("reset_data",  32'(dout[0]), 32'd0);
        chk("reset_ready", 32'(rdy[0]),  32'd0);
        chk("reset_busy",  32'(busy[0]), 32'd0);
        chk("reset_done",  32'(done[0]), 32'd0);
        #1 reset_n = 1'b1;

        foreach (tbl[k]) begin
            start = tbl[k].st; abort = tbl[k].ab; in_valid = tbl[k].v; in_data = tbl[k].d;
            @(negedge clk);
            chk($sformatf("tbl%0d_we", k),    32'(we[0]),   32'(tbl[k].e_we));
            chk($sformatf("tbl%0d_addr", k),  32'(addr[0]), 32'(tbl[k].e_addr));
            chk($sformatf("tbl%0d_data", k),  32'(dout[0]), 32'(tbl[k].e_data));
            chk($sformatf("tbl%0d_ready", k), 32'(rdy[0]),  32'(tbl[k].e_rdy));
            chk($sformatf("tbl%0d_busy", k),  32'(busy[0]), 32'(tbl[k].e_busy));
            chk($sformatf("tbl%0d_done", k),  32'(done[0]), 32'(tbl[k].e_done));
            #1;
        end
        start = 1'b0; abort = 1'b0; in_valid = 1'b0;

        // abort on the cycle of the third accept of the INTERVAL=4 instance
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1;
        found = 0;
        for (int c = 0; c < 100; c++) begin
            if (m_rows[0] == 2 && rdy[0]) begin
                found = 1;
                break;
            end
            in_data = DW'($urandom);
            @(negedge clk); #1;
        end
        chk("abort_reached", 32'(found), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        chk("abort_we",   32'(we[0]),   32'd0);
        chk("abort_busy", 32'(busy[0]), 32'd0);
        chk("abort_done", 32'(done[0]), 32'd0);
        #1 abort = 1'b0;
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        found = 0;
        for (int c = 0; c < 20; c++) begin
            in_data = DW'($urandom);
            @(negedge clk);
            if (we[0]) begin
                found = 1;
                chk("abort_restart_addr", 32'(int'(addr[0]) % DEPTH), 32'd0);
                #1;
                break;
            end
            #1;
        end
        chk("abort_restart_write", 32'(found), 32'd1);
        repeat (3) begin
            @(negedge clk); #1;
        end

        // asynchronous reset between edges, mid-frame
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("arst%0d_we", i),    32'(we[i]),   32'd0);
            chk($sformatf("arst%0d_addr", i),  32'(addr[i]), 32'd0);
            chk($sformatf("arst%0d_data", i),  32'(dout[i]), 32'd0);
            chk($sformatf("arst%0d_ready", i), 32'(rdy[i]),  32'd0);
            chk($sformatf("arst%0d_busy", i),  32'(busy[i]), 32'd0);
            chk($sformatf("arst%0d_done", i),  32'(done[i]), 32'd0);
        end
        in_valid = 1'b0;
        @(negedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk); #1;

        // three frames: bank alternates when enabled, else always 0..3
        for (int f = 0; f < 3; f++) run_frame(f);

        for (int c = 0; c < 1500; c++) begin
            start    = ($urandom % 16) == 0;
            abort    = ($urandom % 64) == 0;
            in_valid = ($urandom % 3) != 0;
            in_data  = DW'($urandom);
            @(negedge clk); #1;
        end
        start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        @(negedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
